// File: rtl/apb_uart_arbiter.sv
// Two-requester round-robin APB arbiter in front of the UART register slave.
// Ports: pclk/preset_n; m_* = two upstream APB requesters (bit/slice i = requester i);
//        s_* = shared downstream APB port; grant_o = one-hot owner; timeout_o = abort pulse.
module apb_uart_arbiter #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                  pclk,
    input  logic                  preset_n,
    input  logic [1:0]            m_psel,
    input  logic [1:0]            m_penable,
    input  logic [1:0]            m_pwrite,
    input  logic [2*ADDR_W-1:0]   m_paddr,
    input  logic [7:0]            m_pstrb,
    input  logic [2*DATA_W-1:0]   m_pwdata,
    output logic [1:0]            m_pready,
    output logic [1:0]            m_pslverr,
    output logic [DATA_W-1:0]     m_prdata,
    output logic                  s_psel,
    output logic                  s_penable,
    output logic                  s_pwrite,
    output logic [ADDR_W-1:0]     s_paddr,
    output logic [3:0]            s_pstrb,
    output logic [DATA_W-1:0]     s_pwdata,
    input  logic                  s_pready,
    input  logic                  s_pslverr,
    input  logic [DATA_W-1:0]     s_prdata,
    output logic [1:0]            grant_o,
    output logic                  timeout_o
);

    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]        state;
    logic              rr;
    logic              gidx;
    logic              dropped;
    logic [TW-1:0]     timer;
    logic              hold_write;
    logic [ADDR_W-1:0] hold_addr;
    logic [3:0]        hold_strb;
    logic [DATA_W-1:0] hold_wdata;
    logic              win;
    logic              live;

    // Arbitration is on psel alone; penable only marks the requester's own phase.
    logic unused_penable;
    assign unused_penable = ^m_penable;

    // Requester 1 wins when it is the only one asking, or both ask and rr points at it.
    assign win  = m_psel[1] & (~m_psel[0] | rr);

    // A requester that let go of psel mid-transfer gets no response.
    assign live = ~dropped & m_psel[gidx];

    assign s_psel    = (state == SETUP) || (state == ACCESS);
    assign s_penable = (state == ACCESS);
    assign s_pwrite  = hold_write;
    assign s_paddr   = hold_addr;
    assign s_pstrb   = hold_strb;
    assign s_pwdata  = hold_wdata;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state      <= IDLE;
            rr         <= 1'b0;
            gidx       <= 1'b0;
            dropped    <= 1'b0;
            timer      <= '0;
            hold_write <= 1'b0;
            hold_addr  <= '0;
            hold_strb  <= '0;
            hold_wdata <= '0;
            grant_o    <= '0;
            m_pready   <= '0;
            m_pslverr  <= '0;
            m_prdata   <= '0;
            timeout_o  <= 1'b0;
        end else begin
            // Response outputs are only ever high for the single DONE cycle.
            m_pready  <= '0;
            m_pslverr <= '0;
            m_prdata  <= '0;
            timeout_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|m_psel) begin
                        gidx       <= win;
                        grant_o    <= win ? 2'b10 : 2'b01;
                        rr         <= ~win;
                        dropped    <= 1'b0;
                        hold_write <= m_pwrite[win];
                        hold_addr  <= win ? m_paddr[ADDR_W +: ADDR_W]
                                          : m_paddr[0 +: ADDR_W];
                        hold_strb  <= win ? m_pstrb[4 +: 4] : m_pstrb[0 +: 4];
                        hold_wdata <= win ? m_pwdata[DATA_W +: DATA_W]
                                          : m_pwdata[0 +: DATA_W];
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    timer <= '0;
                    if (!m_psel[gidx]) dropped <= 1'b1;
                    state <= ACCESS;
                end
                ACCESS: begin
                    if (!m_psel[gidx]) dropped <= 1'b1;
                    if (s_pready) begin
                        state <= DONE;
                        if (live) begin
                            m_pready[gidx]  <= 1'b1;
                            m_pslverr[gidx] <= s_pslverr;
                            m_prdata        <= hold_write ? '0 : s_prdata;
                        end
                    end else if (timer == TMAX) begin
                        state     <= DONE;
                        timeout_o <= 1'b1;
                        if (live) begin
                            m_pready[gidx]  <= 1'b1;
                            m_pslverr[gidx] <= 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DONE: begin
                    grant_o <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_uart_arbiter.sv
// Scoreboard bench for apb_uart_arbiter: directed requester traffic,
// a small downstream slave model, and monitors popping expected responses.
module tb_apb_uart_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;

    logic pclk = 1'b0;
    logic preset_n;
    always #5 pclk = ~pclk;

    logic sel0, sel1, en0, en1, wr0, wr1;
    logic [AW-1:0] addr0, addr1;
    logic [3:0] strb0, strb1;
    logic [DW-1:0] wd0, wd1;

    logic [1:0] m_pready, m_pslverr, grant_o;
    logic [DW-1:0] m_prdata, s_pwdata, s_prdata;
    logic s_psel, s_penable, s_pwrite, s_pready, s_pslverr, timeout_o;
    logic [AW-1:0] s_paddr;
    logic [3:0] s_pstrb;

    apb_uart_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) dut (
        .pclk(pclk), .preset_n(preset_n),
        .m_psel({sel1, sel0}), .m_penable({en1, en0}), .m_pwrite({wr1, wr0}),
        .m_paddr({addr1, addr0}), .m_pstrb({strb1, strb0}), .m_pwdata({wd1, wd0}),
        .m_pready(m_pready), .m_pslverr(m_pslverr), .m_prdata(m_prdata),
        .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
        .s_paddr(s_paddr), .s_pstrb(s_pstrb), .s_pwdata(s_pwdata),
        .s_pready(s_pready), .s_pslverr(s_pslverr), .s_prdata(s_prdata),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    // Downstream slave: ready after slv_wait access cycles, never when hung.
    logic slv_hang, slv_err;
    logic [7:0] slv_wait;
    logic [7:0] wcnt;
    logic [DW-1:0] slv_rdata;

    always @(posedge pclk or negedge preset_n) begin
        if (!preset_n) wcnt <= '0;
        else if (s_psel && s_penable && !s_pready) wcnt <= wcnt + 8'd1;
        else wcnt <= '0;
    end

    assign s_pready  = s_psel & s_penable & ~slv_hang & (wcnt == slv_wait);
    assign s_pslverr = s_pready & slv_err & s_pwrite;
    assign s_prdata  = slv_rdata;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]    rdy;
        logic [1:0]    err;
        logic [DW-1:0] rdata;
        logic          to;
    } rsp_t;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [3:0]    strb;
        logic [DW-1:0] wdata;
    } ds_t;

    rsp_t rq[$];
    ds_t  dq[$];

    task automatic exp_rsp(input logic [1:0] r, input logic [1:0] e,
                           input logic [DW-1:0] d, input logic t);
        rsp_t x;
        x.rdy = r; x.err = e; x.rdata = d; x.to = t;
        rq.push_back(x);
    endtask

    task automatic exp_ds(input logic w, input logic [AW-1:0] a,
                          input logic [3:0] s, input logic [DW-1:0] d);
        ds_t x;
        x.wr = w; x.addr = a; x.strb = s; x.wdata = d;
        dq.push_back(x);
    endtask

    // Monitors: upstream responses and completed downstream transfers.
    always @(negedge pclk) begin
        if (preset_n && m_pready != 2'b00) begin
            if (rq.size() == 0) begin
                chk("rsp_unexpected", {62'd0, m_pready}, 64'd0);
            end else begin
                rsp_t e;
                e = rq.pop_front();
                chk("rsp_ready", {62'd0, m_pready}, {62'd0, e.rdy});
                chk("rsp_slverr", {62'd0, m_pslverr}, {62'd0, e.err});
                chk("rsp_rdata", {32'd0, m_prdata}, {32'd0, e.rdata});
                chk("rsp_timeout", {63'd0, timeout_o}, {63'd0, e.to});
                chk("done_s_psel", {63'd0, s_psel}, 64'd0);
            end
        end
        if (preset_n && s_psel && s_penable && s_pready) begin
            if (dq.size() == 0) begin
                chk("ds_unexpected", {63'd0, s_pready}, 64'd0);
            end else begin
                ds_t d;
                d = dq.pop_front();
                chk("ds_write", {63'd0, s_pwrite}, {63'd0, d.wr});
                chk("ds_addr", {52'd0, s_paddr}, {52'd0, d.addr});
                chk("ds_strb", {60'd0, s_pstrb}, {60'd0, d.strb});
                chk("ds_wdata", {32'd0, s_pwdata}, {32'd0, d.wdata});
            end
        end
    end

    task automatic xfer(input int i, input logic w, input logic [AW-1:0] a,
                        input logic [3:0] s, input logic [DW-1:0] d);
        int n;
        @(posedge pclk); #1;
        if (i == 0) begin
            sel0 = 1; wr0 = w; addr0 = a; strb0 = s; wd0 = d;
        end else begin
            sel1 = 1; wr1 = w; addr1 = a; strb1 = s; wd1 = d;
        end
        @(posedge pclk); #1;
        if (i == 0) en0 = 1; else en1 = 1;
        n = 0;
        do begin
            @(negedge pclk);
            n++;
        end while (!m_pready[i] && n < 200);
        chk("xfer_wait_bound", {63'd0, m_pready[i]}, 64'd1);
        @(posedge pclk); #1;
        if (i == 0) begin sel0 = 0; en0 = 0; end
        else begin sel1 = 0; en1 = 0; end
    endtask

    task automatic do_reset();
        preset_n = 0;
        repeat (2) @(posedge pclk);
        #1 preset_n = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got hang want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sel0 = 0; sel1 = 0; en0 = 0; en1 = 0; wr0 = 0; wr1 = 0;
        addr0 = '0; addr1 = '0; strb0 = '0; strb1 = '0; wd0 = '0; wd1 = '0;
        slv_hang = 0; slv_err = 0; slv_wait = 0; slv_rdata = 32'hA5;
        preset_n = 0;
        #1;
        chk("reset_outs_a",
            {28'd0, m_pready, m_pslverr, m_prdata},
            64'd0);
        chk("reset_outs_b",
            {36'd0, s_psel, s_penable, s_pwrite, s_paddr, s_pstrb,
             grant_o, timeout_o, 5'd0},
            64'd0);
        chk("reset_pwdata", {32'd0, s_pwdata}, 64'd0);
        repeat (2) @(posedge pclk);
        #1 preset_n = 1;

        // Single m0 write, zero-wait slave: latency T+1/T+2/T+3.
        exp_ds(1, 12'h008, 4'hF, 32'h55);
        exp_rsp(2'b01, 2'b00, 32'h0, 0);
        fork
            xfer(0, 1, 12'h008, 4'hF, 32'h55);
            begin
                @(posedge pclk);
                @(negedge pclk);
                chk("lat_T_s_psel", {63'd0, s_psel}, 64'd0);
                @(negedge pclk);
                chk("lat_T1_setup", {61'd0, s_psel, s_penable, grant_o == 2'b01},
                    64'b101);
                @(negedge pclk);
                chk("lat_T2_access", {62'd0, s_psel, s_penable}, 64'b11);
                @(negedge pclk);
                chk("lat_T3_pready", {60'd0, m_pready, grant_o}, 64'b0101);
            end
        join

        // Simultaneous reads from reset: strict alternation m0,m1,m0,m1.
        do_reset();
        slv_rdata = 32'hA5;
        exp_ds(0, 12'h004, 4'hF, 32'h0); exp_rsp(2'b01, 2'b00, 32'hA5, 0);
        exp_ds(0, 12'h00C, 4'hF, 32'h0); exp_rsp(2'b10, 2'b00, 32'hA5, 0);
        exp_ds(0, 12'h014, 4'hF, 32'h0); exp_rsp(2'b01, 2'b00, 32'hA5, 0);
        exp_ds(0, 12'h01C, 4'hF, 32'h0); exp_rsp(2'b10, 2'b00, 32'hA5, 0);
        fork
            xfer(0, 0, 12'h004, 4'hF, 32'h0);
            xfer(1, 0, 12'h00C, 4'hF, 32'h0);
        join
        fork
            xfer(0, 0, 12'h014, 4'hF, 32'h0);
            xfer(1, 0, 12'h01C, 4'hF, 32'h0);
        join

        // m1 read against a hung slave: 16 access cycles then abort.
        slv_hang = 1;
        exp_rsp(2'b10, 2'b10, 32'h0, 1);
        fork
            xfer(1, 0, 12'h010, 4'hF, 32'h0);
            begin
                int c = 0;
                int n = 0;
                while (!s_penable && n < 50) begin
                    @(negedge pclk);
                    n++;
                end
                while (s_penable && c < 100) begin
                    c++;
                    @(negedge pclk);
                end
                chk("timeout_access_cycles", c, 64'd16);
            end
        join
        slv_hang = 0;

        // m0 write with 3 waits and slave error; m1 waits, then served.
        slv_wait = 3; slv_err = 1; slv_rdata = 32'h5A5A_0001;
        exp_ds(1, 12'h020, 4'h3, 32'h1234); exp_rsp(2'b01, 2'b01, 32'h0, 0);
        exp_ds(0, 12'h030, 4'hF, 32'h0);
        exp_rsp(2'b10, 2'b00, 32'h5A5A_0001, 0);
        fork
            xfer(0, 1, 12'h020, 4'h3, 32'h1234);
            xfer(1, 0, 12'h030, 4'hF, 32'h0);
        join
        slv_wait = 0; slv_err = 0;

        // Reset during m0 access; pending m1 completes after release.
        slv_hang = 1; slv_rdata = 32'hC3;
        exp_ds(0, 12'h040, 4'hF, 32'h0); exp_rsp(2'b10, 2'b00, 32'hC3, 0);
        fork
            xfer(1, 0, 12'h040, 4'hF, 32'h0);
            begin
                int n = 0;
                @(posedge pclk); #1;
                sel0 = 1; wr0 = 1; addr0 = 12'h050; strb0 = 4'hF;
                wd0 = 32'hDEAD_BEEF;
                @(posedge pclk); #1;
                en0 = 1;
                while (!s_penable && n < 50) begin
                    @(negedge pclk);
                    n++;
                end
                chk("rst_grant_m0", {62'd0, grant_o}, 64'b01);
                @(posedge pclk); #1;
                preset_n = 0;
                #1;
                chk("midrst_outs_a",
                    {28'd0, m_pready, m_pslverr, m_prdata}, 64'd0);
                chk("midrst_outs_b",
                    {36'd0, s_psel, s_penable, s_pwrite, s_paddr, s_pstrb,
                     grant_o, timeout_o, 5'd0},
                    64'd0);
                sel0 = 0; en0 = 0; slv_hang = 0;
                @(posedge pclk); #1;
                preset_n = 1;
            end
        join

        repeat (3) @(posedge pclk);
        chk("rsp_queue_empty", rq.size(), 64'd0);
        chk("ds_queue_empty", dq.size(), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
